ecc_mult_sched: RTL and testbench

//  - Multi-word multiplier sequencer for the ECC datapath.
//  - Computes a full REG_SIZE x REG_SIZE product by time-sharing one RADIX x RADIX ecc_mult_dsp instance.
//  - Uses product (column) scanning: one partial product per cycle.
//  - Sits between the ECC arithmetic unit (requester) and the DSP multiplier.

---
 rtl/ecc_mult_sched_pkg.sv | 23 ++
 rtl/ecc_mult_dsp.sv | 13 +
 rtl/ecc_mult_sched.sv | 201 ++++++++++++++++++++
 tb/tb_ecc_mult_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_mult_sched_pkg.sv
// Shared types and sizing for the ECC multi-word multiplier sequencer.
// Module parameters default to the constants below.
package ecc_mult_sched_pkg;

  localparam int ECC_RADIX     = 32;
  localparam int ECC_NUM_WORDS = 12;
  localparam int REG_SIZE      = ECC_NUM_WORDS * ECC_RADIX;
  localparam int ACC_W         = 2 * ECC_RADIX + $clog2(ECC_NUM_WORDS);
  localparam int CNT_W         = $clog2(2 * ECC_NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // First operand-A word index that contributes to product column k.
  function automatic int col_start(input int k, input int n);
    return (k > n - 1) ? (k - n + 1) : 0;
  endfunction

endpackage

// File: rtl/ecc_mult_dsp.sv
// Single RADIX x RADIX unsigned multiplier used by the ECC datapath.
// Purely combinational; any output register lives in the caller.
module ecc_mult_dsp #(
  parameter int RADIX = 32
) (
  input  logic [RADIX-1:0]   a_i,
  input  logic [RADIX-1:0]   b_i,
  output logic [2*RADIX-1:0] p_o
);

  assign p_o = {{RADIX{1'b0}}, a_i} * {{RADIX{1'b0}}, b_i};

endmodule

// File: rtl/ecc_mult_sched.sv
// Product-scanning sequencer: one partial product per cycle through one ecc_mult_dsp.
// Optional macro ECC_MULT_SCHED_PIPE_EN adds a register stage on the DSP output.
module ecc_mult_sched
  import ecc_mult_sched_pkg::*;
#(
  parameter int RADIX     = ECC_RADIX,
  parameter int NUM_WORDS = ECC_NUM_WORDS
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          zeroize,
  input  logic                          start_i,
  input  logic [NUM_WORDS*RADIX-1:0]    opa_i,
  input  logic [NUM_WORDS*RADIX-1:0]    opb_i,
  output logic                          ready_o,
  output logic [2*NUM_WORDS*RADIX-1:0]  res_o,
  output logic                          res_valid_o
);

  localparam int RS = NUM_WORDS * RADIX;
  localparam int AW = 2 * RADIX + $clog2(NUM_WORDS);
  localparam int CW = $clog2(2 * NUM_WORDS);
  localparam logic [CW-1:0] K_LAST = CW'(2 * NUM_WORDS - 2);
  localparam logic [CW-1:0] K_END  = CW'(2 * NUM_WORDS - 1);
  localparam logic [CW-1:0] I_MAX  = CW'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  logic [RS-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic [CW-1:0]     k_q, k_d, i_q, i_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [2*RS-1:0]   res_q, res_d;

  logic [CW-1:0]      j_idx, col_end;
  logic [RADIX-1:0]   a_word, b_word;
  logic [2*RADIX-1:0] prod;
  logic               issue_vld, retire_iss;

  logic [2*RADIX-1:0] acc_p;
  logic               acc_vld, acc_ret;
  logic [CW-1:0]      acc_kw;
  logic [AW-1:0]      acc_sum;
  logic               accept;

  // Issue stage: select operand words for the current (k, i) and multiply
  assign issue_vld  = (state_q == MAC) && (k_q != K_END);
  assign j_idx      = k_q - i_q;
  assign col_end    = (k_q >= I_MAX) ? I_MAX : k_q;
  assign retire_iss = issue_vld && (i_q == col_end);

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (i_q == CW'(w))   a_word = opa_q[w*RADIX +: RADIX];
      if (j_idx == CW'(w)) b_word = opb_q[w*RADIX +: RADIX];
    end
  end

  ecc_mult_dsp #(.RADIX(RADIX)) u_dsp (
    .a_i (a_word),
    .b_i (b_word),
    .p_o (prod)
  );

`ifdef ECC_MULT_SCHED_PIPE_EN
  logic [2*RADIX-1:0] prod_p1;
  logic               vld_p1, ret_p1;
  logic [CW-1:0]      kw_p1;

  // Pipeline stage p1: registered product with its column-retire control
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      ret_p1  <= 1'b0;
      kw_p1   <= '0;
    end else if (zeroize) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      ret_p1  <= 1'b0;
      kw_p1   <= '0;
    end else begin
      prod_p1 <= prod;
      vld_p1  <= issue_vld;
      ret_p1  <= retire_iss;
      kw_p1   <= k_q;
    end
  end

  assign acc_p   = prod_p1;
  assign acc_vld = vld_p1;
  assign acc_ret = ret_p1;
  assign acc_kw  = kw_p1;
`else
  assign acc_p   = prod;
  assign acc_vld = issue_vld;
  assign acc_ret = retire_iss;
  assign acc_kw  = k_q;
`endif

  // Accumulate stage
  assign acc_sum = acc_q + AW'(acc_p);

  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    k_d         = k_q;
    i_d         = i_q;
    acc_d       = acc_q;
    res_d       = res_q;
    ready_o     = 1'b0;
    res_valid_o = 1'b0;
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        accept  = start_i;
      end
      MAC: begin
        if (issue_vld) begin
          if (retire_iss) begin
            k_d = k_q + 1'b1;
            i_d = CW'(col_start(int'(k_q) + 1, NUM_WORDS));
          end else begin
            i_d = i_q + 1'b1;
          end
        end
        if (acc_vld) begin
          if (acc_ret) begin
            for (int w = 0; w < 2 * NUM_WORDS; w++) begin
              if (acc_kw == CW'(w)) res_d[w*RADIX +: RADIX] = acc_sum[RADIX-1:0];
            end
            acc_d = acc_sum >> RADIX;
            if (acc_kw == K_LAST) state_d = FIN;
          end else begin
            acc_d = acc_sum;
          end
        end
      end
      FIN: begin
        res_d[(2*NUM_WORDS-1)*RADIX +: RADIX] = acc_q[RADIX-1:0];
        state_d = DONE;
      end
      DONE: begin
        ready_o     = 1'b1;
        res_valid_o = 1'b1;
        state_d     = IDLE;
        accept      = start_i;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = MAC;
      opa_d   = opa_i;
      opb_d   = opb_i;
      k_d     = '0;
      i_d     = '0;
      acc_d   = '0;
    end

    // Zeroize outranks any start sampled in the same cycle
    if (zeroize) begin
      state_d = IDLE;
      opa_d   = '0;
      opb_d   = '0;
      k_d     = '0;
      i_d     = '0;
      acc_d   = '0;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa_q <= '0;
      opb_q <= '0;
      k_q   <= '0;
      i_q   <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      opa_q <= opa_d;
      opb_q <= opb_d;
      k_q   <= k_d;
      i_q   <= i_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: tb/tb_ecc_mult_sched.sv
// Directed self-checking bench for ecc_mult_sched (N=12, RADIX=32), both build variants.
module tb_ecc_mult_sched;

  localparam int N  = 12;
  localparam int R  = 32;
  localparam int RS = N * R;
`ifdef ECC_MULT_SCHED_PIPE_EN
  localparam int LAT = N * N + 3;
`else
  localparam int LAT = N * N + 2;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            zeroize = 1'b0;
  logic            start_i = 1'b0;
  logic [RS-1:0]   opa_i = '0;
  logic [RS-1:0]   opb_i = '0;
  logic            ready_o;
  logic [2*RS-1:0] res_o;
  logic            res_valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  ecc_mult_sched dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .zeroize     (zeroize),
    .start_i     (start_i),
    .opa_i       (opa_i),
    .opb_i       (opb_i),
    .ready_o     (ready_o),
    .res_o       (res_o),
    .res_valid_o (res_valid_o)
  );

  always #5 clk = ~clk;

  // Drive a start; returns 1 ns after the accepting edge with operands scrambled.
  task automatic issue(input logic [RS-1:0] a, input logic [RS-1:0] b);
    start_i = 1'b1;
    opa_i   = a;
    opb_i   = b;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    opa_i   = ~a;
    opb_i   = ~b ^ {N{32'h5A5A5A5A}};
  endtask

  // lat = n when res_valid_o is seen just before edge T+n; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= LAT + 20; n++) begin
      @(negedge clk);
      if (res_valid_o) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [RS-1:0] a, input logic [RS-1:0] b,
                        output int lat, output logic [2*RS-1:0] res);
    issue(a, b);
    wait_valid(lat);
    res = res_o;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready_o); end
    n_checks++;
    if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", res_valid_o); end
    n_checks++;
    if (res_o !== '0) begin n_fail++; $display("FAIL rst_res: got %h want 0", res_o); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ones();
    int lat;
    logic [2*RS-1:0] res;
    run_op(RS'(1), RS'(1), lat, res);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL t1_latency: got %0d want %0d", lat, LAT); end
    n_checks++;
    if (res !== 768'd1) begin n_fail++; $display("FAIL t1_res: got %h want 1", res); end
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL t1_ready_done: got %b want 1", ready_o); end
    @(negedge clk);
    n_checks++;
    if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL t1_pulse_width: got %b want 0", res_valid_o); end
    n_checks++;
    if (res_o !== 768'd1) begin n_fail++; $display("FAIL t1_res_held: got %h want 1", res_o); end
  endtask

  task automatic test_max();
    int lat;
    logic [2*RS-1:0] res, exp;
    exp = 768'd1 - (768'd1 << 385);
    @(negedge clk);
    run_op({RS{1'b1}}, {RS{1'b1}}, lat, res);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL t2_latency: got %0d want %0d", lat, LAT); end
    n_checks++;
    if (res !== exp) begin n_fail++; $display("FAIL t2_res: got %h want %h", res, exp); end
  endtask

  task automatic test_zero_and_shift();
    int lat;
    logic [2*RS-1:0] res;
    logic [RS-1:0] rnd;
    for (int w = 0; w < N; w++) rnd[w*R +: R] = $urandom;
    @(negedge clk);
    run_op('0, rnd, lat, res);
    n_checks++;
    if (res !== '0) begin n_fail++; $display("FAIL t3_zero: got %h want 0", res); end
    @(negedge clk);
    run_op(RS'(1) << 383, RS'(2), lat, res);
    n_checks++;
    if (res !== (768'd1 << 384)) begin n_fail++; $display("FAIL t3_shift: got %h want 2^384", res); end
  endtask

  task automatic test_pattern();
    int lat;
    logic [2*RS-1:0] res, exp;
    logic [RS-1:0] a, b;
    a = {N{32'h89ABCDEF}};
    b = {{6{32'hFFFFFFFF}}, {6{32'h00000003}}};
    exp = {{RS{1'b0}}, a} * {{RS{1'b0}}, b};
    @(negedge clk);
    run_op(a, b, lat, res);
    n_checks++;
    if (res !== exp) begin n_fail++; $display("FAIL pattern_res: got %h want %h", res, exp); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [2*RS-1:0] res1, exp1, exp2;
    logic [RS-1:0] a1, b1, a2, b2;
    a1 = {N{32'h12345678}};
    b1 = {N{32'hFEDCBA98}};
    a2 = {{11{32'h0}}, 32'hFFFFFFFF};
    b2 = {N{32'hFFFFFFFF}};
    exp1 = {{RS{1'b0}}, a1} * {{RS{1'b0}}, b1};
    exp2 = {{RS{1'b0}}, a2} * {{RS{1'b0}}, b2};
    @(negedge clk);
    run_op(a1, b1, lat1, res1);
    n_checks++;
    if (res1 !== exp1) begin n_fail++; $display("FAIL t4_first_res: got %h want %h", res1, exp1); end
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL t4_ready_in_done: got %b want 1", ready_o); end
    issue(a2, b2);
    n_checks++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL t4_accept_no_bubble: ready got %b want 0", ready_o); end
    wait_valid(lat2);
    n_checks++;
    if (lat2 !== LAT) begin n_fail++; $display("FAIL t4_second_latency: got %0d want %0d", lat2, LAT); end
    n_checks++;
    if (res_o !== exp2) begin n_fail++; $display("FAIL t4_second_res: got %h want %h", res_o, exp2); end
  endtask

  task automatic test_start_ignored();
    int lat;
    bit ready_early;
    logic [2*RS-1:0] exp;
    logic [RS-1:0] a, b;
    a = {N{32'hCAFEF00D}};
    b = {N{32'h0BADBEEF}};
    exp = {{RS{1'b0}}, a} * {{RS{1'b0}}, b};
    ready_early = 1'b0;
    lat = -1;
    @(negedge clk);
    issue(a, b);
    for (int n = 1; n <= LAT + 20; n++) begin
      @(negedge clk);
      if (res_valid_o) begin
        lat = n;
        break;
      end
      if (ready_o) ready_early = 1'b1;
      if ((n >= 20 && n <= 22) || n == 60) begin
        start_i = 1'b1;
        opa_i   = RS'(n);
        opb_i   = {RS{1'b1}};
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    n_checks++;
    if (ready_early !== 1'b0) begin n_fail++; $display("FAIL t5_ready_busy: got %b want 0", ready_early); end
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL t5_latency: got %0d want %0d", lat, LAT); end
    n_checks++;
    if (res_o !== exp) begin n_fail++; $display("FAIL t5_res: got %h want %h", res_o, exp); end
  endtask

  task automatic test_abort();
    int lat;
    bit seen;
    logic [2*RS-1:0] res, exp;
    logic [RS-1:0] a, b;
    a = {N{32'h76543210}};
    b = {N{32'h01234567}};
    exp = {{RS{1'b0}}, a} * {{RS{1'b0}}, b};

    // reset_n mid-operation
    @(negedge clk);
    issue({RS{1'b1}}, {RS{1'b1}});
    repeat (49) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL t6_rst_ready: got %b want 1", ready_o); end
    n_checks++;
    if (res_o !== '0) begin n_fail++; $display("FAIL t6_rst_res: got %h want 0", res_o); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < LAT + 5; n++) begin
      @(negedge clk);
      if (res_valid_o) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL t6_rst_no_valid: got %b want 0", seen); end
    run_op(a, b, lat, res);
    n_checks++;
    if (res !== exp) begin n_fail++; $display("FAIL t6_rst_next_res: got %h want %h", res, exp); end

    // zeroize mid-operation, with a prior result held in res_o
    @(negedge clk);
    issue(b, a);
    repeat (49) @(negedge clk);
    zeroize = 1'b1;
    @(posedge clk);
    #1;
    zeroize = 1'b0;
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL t6_zero_ready: got %b want 1", ready_o); end
    n_checks++;
    if (res_o !== '0) begin n_fail++; $display("FAIL t6_zero_res: got %h want 0", res_o); end

    // zeroize coinciding with start drops the start
    @(negedge clk);
    zeroize = 1'b1;
    start_i = 1'b1;
    opa_i   = a;
    opb_i   = b;
    @(posedge clk);
    #1;
    zeroize = 1'b0;
    start_i = 1'b0;
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL t6_zero_start_dropped: ready got %b want 1", ready_o); end
    seen = 1'b0;
    for (int n = 0; n < LAT + 5; n++) begin
      @(negedge clk);
      if (res_valid_o) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL t6_zero_no_valid: got %b want 0", seen); end
    run_op(a, b, lat, res);
    n_checks++;
    if (res !== exp) begin n_fail++; $display("FAIL t6_zero_next_res: got %h want %h", res, exp); end
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL t6_zero_next_latency: got %0d want %0d", lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_max();
    test_zero_and_shift();
    test_pattern();
    test_back_to_back();
    test_start_ignored();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
